regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Register-file writeback arbiter with issue scoreboard.
//            Two writeback sources (ALU, load unit) are arbitrated
//            round-robin onto a single registered register-file write
//            port. A 32-entry busy scoreboard stalls issue on RAW/WAW
//            hazards. Writebacks to a non-busy register raise a sticky
//            error flag.
// Ports    : clk, reset                     clock, async active-high reset
//            iss_valid/rs1/rs2/rd -> iss_stall    issue hazard check
//            alu_valid/rd/data   -> alu_ready     ALU writeback request
//            mem_valid/rd/data   -> mem_ready     load writeback request
//            rf_we/rf_waddr/rf_wdata              registered RF write port
//            busy_vec                             scoreboard bits
//            wb_err                               sticky writeback error
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_vec,
  output logic            wb_err
);

  // Last-grant pointer: which requester won most recently.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } last_t;

  last_t             last_q, last_d;
  logic [31:0]       busy_q, busy_d;
  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              w_hazard;
  logic              w_issue_ok;
  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_gnt;
  logic [4:0]        w_rd;
  logic [XLEN-1:0]   w_data;
  logic              w_wr;

  // Grant and issue decisions used for next state are left ungated by
  // reset: while reset is high the registers are held cleared anyway, so
  // only the externally visible handshakes need the reset qualifier.
  always_comb begin
    w_hazard   = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd];
    w_issue_ok = iss_valid & ~w_hazard;

    // On conflict, the requester that did not win last time wins now.
    w_alu_gnt  = alu_valid & (~mem_valid | (last_q == LAST_MEM));
    w_mem_gnt  = mem_valid & (~alu_valid | (last_q == LAST_ALU));
    w_gnt      = w_alu_gnt | w_mem_gnt;
    w_rd       = w_alu_gnt ? alu_rd   : mem_rd;
    w_data     = w_alu_gnt ? alu_data : mem_data;
    // Writes to x0 complete the handshake but never reach the port.
    w_wr       = w_gnt & (w_rd != 5'd0);
  end

  always_comb begin
    iss_stall = ~reset & iss_valid & w_hazard;
    alu_ready = ~reset & w_alu_gnt;
    mem_ready = ~reset & w_mem_gnt;
  end

  always_comb begin
    busy_d  = busy_q;
    last_d  = last_q;
    we_d    = w_wr;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    if (w_gnt) begin
      last_d = w_alu_gnt ? LAST_ALU : LAST_MEM;
    end

    if (w_wr) begin
      waddr_d = w_rd;
      wdata_d = w_data;
      // Writing back a register nobody is waiting on is a protocol error.
      if (!busy_q[w_rd]) begin
        err_d = 1'b1;
      end
      busy_d[w_rd] = 1'b0;
    end

    // Applied after the clear so a same-edge issue to the same register
    // keeps the bit set.
    if (w_issue_ok && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end

    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= LAST_MEM;
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy_vec = busy_q;
  assign wb_err   = err_q;

endmodule
`default_nettype wire
